// File: rtl/uart_frame_rx.sv
// Score-link deframer: pops UART RX bytes, hunts for the sync byte, checks each
// 6-byte frame and holds the last good one as {P2,P1,P0,ID}.
//
// state  | meaning
// HUNT   | discarding bytes until the sync byte is seen
// GET_ID | next byte is the remote board ID (any value)
// GET_P2 | next byte is the most significant BCD score byte
// GET_P1 | next byte is the middle BCD score byte
// GET_P0 | next byte is the least significant BCD score byte
// GET_CS | next byte is the XOR checksum; frame is judged here

module uart_frame_rx #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         GAP_CYCLES   = 750_000,
    parameter int         LINK_TIMEOUT = 75_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_empty,
    input  logic [7:0]  rx_data,
    output logic        rd_uart,
    output logic [31:0] ext_data,
    output logic        frame_valid,
    output logic        link_up,
    output logic [7:0]  err_cnt
);

    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int LINK_W = $clog2(LINK_TIMEOUT + 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [LINK_W-1:0] LINK_LAST = LINK_W'(LINK_TIMEOUT - 1);
    localparam logic [LINK_W-1:0] LINK_MAX  = LINK_W'(LINK_TIMEOUT);

    typedef enum logic [2:0] {
        HUNT,
        GET_ID,
        GET_P2,
        GET_P1,
        GET_P0,
        GET_CS
    } state_t;

    state_t state, next_state;

    logic [7:0]        id_q, p2_q, p1_q, p0_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic [LINK_W-1:0] link_cnt;

    logic pop;
    logic is_sync;
    logic frame_good;
    logic err_inc;
    logic gap_expire;

    function automatic logic is_bcd(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    assign rd_uart = ~rx_empty & ~rst;
    assign pop     = rd_uart;
    assign is_sync = (rx_data == SYNC_BYTE);

    always_comb begin
        next_state = state;
        frame_good = 1'b0;
        err_inc    = 1'b0;
        gap_expire = 1'b0;
        case (state)
            HUNT: begin
                if (pop && is_sync) next_state = GET_ID;
            end
            GET_ID: begin
                if (pop) next_state = GET_P2;
            end
            GET_P2, GET_P1, GET_P0: begin
                if (pop) begin
                    if (is_sync) begin
                        err_inc    = 1'b1;
                        next_state = GET_ID;
                    end else if (state == GET_P2) begin
                        next_state = GET_P1;
                    end else if (state == GET_P1) begin
                        next_state = GET_P0;
                    end else begin
                        next_state = GET_CS;
                    end
                end
            end
            GET_CS: begin
                if (pop) begin
                    frame_good = (rx_data == (id_q ^ p2_q ^ p1_q ^ p0_q)) &&
                                 is_bcd(p2_q) && is_bcd(p1_q) && is_bcd(p0_q) &&
                                 (id_q != 8'h00);
                    err_inc    = ~frame_good;
                    next_state = HUNT;
                end
            end
            default: next_state = HUNT;
        endcase

        // An idle mid-frame cycle can only expire the gap when no pop happens
        if (state != HUNT && !pop && gap_cnt == GAP_LAST) begin
            gap_expire = 1'b1;
            err_inc    = 1'b1;
            next_state = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q <= 8'h00;
            p2_q <= 8'h00;
            p1_q <= 8'h00;
            p0_q <= 8'h00;
        end else if (pop) begin
            case (state)
                GET_ID:  id_q <= rx_data;
                GET_P2:  p2_q <= rx_data;
                GET_P1:  p1_q <= rx_data;
                GET_P0:  p0_q <= rx_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == HUNT || pop || gap_expire) gap_cnt <= '0;
        else                                          gap_cnt <= gap_cnt + GAP_W'(1);
    end

    // A good frame takes priority over a link timer expiring on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            link_cnt    <= '0;
            ext_data    <= 32'h0;
            link_up     <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_good;
            if (frame_good) begin
                link_cnt <= '0;
                ext_data <= {p2_q, p1_q, p0_q, id_q};
                link_up  <= 1'b1;
            end else if (link_cnt != LINK_MAX) begin
                link_cnt <= link_cnt + LINK_W'(1);
                if (link_cnt == LINK_LAST) begin
                    ext_data <= 32'h0;
                    link_up  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                            err_cnt <= 8'h00;
        else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed scenarios plus randomized byte streams,
// all checked against a byte-level reference model of the frame rules.

module tb_uart_frame_rx;

    localparam int         GAP  = 16;
    localparam int         LINK = 100;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_empty = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rd_uart;
    logic [31:0] ext_data;
    logic        frame_valid;
    logic        link_up;
    logic [7:0]  err_cnt;

    uart_frame_rx #(
        .SYNC_BYTE   (SYNC),
        .GAP_CYCLES  (GAP),
        .LINK_TIMEOUT(LINK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
        .rd_uart    (rd_uart),
        .ext_data   (ext_data),
        .frame_valid(frame_valid),
        .link_up    (link_up),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          m_in_frame;
    logic [7:0]  m_buf[$];
    int          m_gap;
    int          m_link;
    logic [31:0] m_ext;
    bit          m_up;
    int          m_err;
    bit          m_fv;

    int dut_fv_cnt = 0;
    int mdl_fv_cnt = 0;
    int div_cnt    = 0;

    logic [7:0] tx_q[$];

    function automatic logic [7:0] csum(input logic [7:0] id, p2, p1, p0);
        return id ^ p2 ^ p1 ^ p0;
    endfunction

    function automatic bit bcd_ok(input logic [7:0] b);
        return (b[7:4] < 10) && (b[3:0] < 10);
    endfunction

    function automatic logic [7:0] rand_bcd();
        logic [3:0] hi, lo;
        hi = 4'($urandom_range(0, 9));
        lo = 4'($urandom_range(0, 9));
        return {hi, lo};
    endfunction

    task automatic model_reset();
        m_in_frame = 0;
        m_buf.delete();
        m_gap  = 0;
        m_link = 0;
        m_ext  = 32'h0;
        m_up   = 0;
        m_err  = 0;
        m_fv   = 0;
    endtask

    task automatic model_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_edge(input bit has, input logic [7:0] b);
        bit good;
        good = 0;
        m_fv = 0;
        if (!has && m_in_frame) begin
            m_gap++;
            if (m_gap == GAP) begin
                m_in_frame = 0;
                m_gap      = 0;
                model_err();
            end
        end
        if (has) begin
            m_gap = 0;
            if (!m_in_frame) begin
                if (b == SYNC) begin
                    m_in_frame = 1;
                    m_buf.delete();
                end
            end else begin
                m_buf.push_back(b);
                if (m_buf.size() >= 2 && m_buf.size() <= 4 && b == SYNC) begin
                    model_err();
                    m_buf.delete();
                end else if (m_buf.size() == 5) begin
                    good = (m_buf[4] == (m_buf[0] ^ m_buf[1] ^ m_buf[2] ^ m_buf[3])) &&
                           bcd_ok(m_buf[1]) && bcd_ok(m_buf[2]) && bcd_ok(m_buf[3]) &&
                           (m_buf[0] != 8'h00);
                    if (!good) model_err();
                    m_in_frame = 0;
                end
            end
        end
        if (good) begin
            m_ext  = {m_buf[1], m_buf[2], m_buf[3], m_buf[0]};
            m_up   = 1;
            m_link = 0;
            m_fv   = 1;
        end else if (m_link < LINK) begin
            m_link++;
            if (m_link == LINK) begin
                m_up  = 0;
                m_ext = 32'h0;
            end
        end
    endtask

    // one clock cycle, optionally offering a byte; model and DUT tracked together
    task automatic tick(input bit has, input logic [7:0] b);
        @(negedge clk);
        rx_empty = !has;
        rx_data  = has ? b : 8'($urandom);
        @(posedge clk);
        model_edge(has, b);
        #1;
        if (frame_valid) dut_fv_cnt++;
        if (m_fv) mdl_fv_cnt++;
        if (ext_data !== m_ext || link_up !== m_up || err_cnt !== 8'(m_err) ||
            frame_valid !== m_fv)
            div_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 8'h00);
    endtask

    task automatic send_q();
        foreach (tx_q[i]) tick(1, tx_q[i]);
    endtask

    task automatic send_frame(input logic [7:0] id, p2, p1, p0);
        tx_q = '{SYNC, id, p2, p1, p0, csum(id, p2, p1, p0)};
        send_q();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_empty = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_empty = 1'b0;
        rx_data  = SYNC;
        #1;
        total++; if (rd_uart !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b want 0", rd_uart); end
        @(posedge clk);
        @(posedge clk);
        #1;
        total++; if (ext_data !== 32'h0) begin bad++; $display("FAIL reset_ext: got %h want 0", ext_data); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
        total++; if (link_up !== 1'b0) begin bad++; $display("FAIL reset_link: got %b want 0", link_up); end
        total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL reset_err: got %h want 0", err_cnt); end
        rst = 1'b0;
        #1;
        total++; if (rd_uart !== 1'b1) begin bad++; $display("FAIL rd_follow: got %b want 1", rd_uart); end
        rx_empty = 1'b1;
        #1;
        total++; if (rd_uart !== 1'b0) begin bad++; $display("FAIL rd_empty: got %b want 0", rd_uart); end
        model_reset();
    endtask

    task automatic test_back_to_back();
        int fv0, div0;
        do_reset();
        fv0  = dut_fv_cnt;
        div0 = div_cnt;
        send_frame(8'h03, 8'h00, 8'h12, 8'h34);
        total++; if (ext_data !== 32'h00123403) begin bad++; $display("FAIL b2b_first: got %h want 00123403", ext_data); end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_pulse: got %b want 1", frame_valid); end
        total++; if (link_up !== 1'b1) begin bad++; $display("FAIL b2b_link: got %b want 1", link_up); end
        send_frame(8'h07, 8'h98, 8'h76, 8'h54);
        total++; if (ext_data !== 32'h98765407) begin bad++; $display("FAIL b2b_second: got %h want 98765407", ext_data); end
        idle(1);
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse_end: got %b want 0", frame_valid); end
        total++; if (dut_fv_cnt - fv0 !== 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", dut_fv_cnt - fv0); end
        total++; if (div_cnt !== div0) begin bad++; $display("FAIL b2b_model: got %0d divergent cycles want 0", div_cnt - div0); end
    endtask

    task automatic test_bad_frames();
        int fv0;
        do_reset();
        send_frame(8'h03, 8'h00, 8'h12, 8'h34);
        fv0 = dut_fv_cnt;
        tx_q = '{SYNC, 8'h03, 8'h00, 8'h12, 8'h34, 8'h00};
        send_q();
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL bad_cs_err: got %0d want 1", err_cnt); end
        total++; if (ext_data !== 32'h00123403) begin bad++; $display("FAIL bad_cs_ext: got %h want 00123403", ext_data); end
        send_frame(8'h03, 8'h00, 8'h1A, 8'h34);
        total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL non_bcd_err: got %0d want 2", err_cnt); end
        send_frame(8'h00, 8'h00, 8'h12, 8'h34);
        total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL id0_err: got %0d want 3", err_cnt); end
        total++; if (dut_fv_cnt !== fv0) begin bad++; $display("FAIL bad_no_pulse: got %0d pulses want 0", dut_fv_cnt - fv0); end
        total++; if (ext_data !== 32'h00123403) begin bad++; $display("FAIL bad_ext_kept: got %h want 00123403", ext_data); end
        send_frame(8'hFF, 8'h99, 8'h99, 8'h99);
        total++; if (ext_data !== 32'h999999FF) begin bad++; $display("FAIL bcd_max: got %h want 999999ff", ext_data); end
        total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL bcd_max_err: got %0d want 3", err_cnt); end
    endtask

    task automatic test_resync();
        int fv0;
        do_reset();
        fv0 = dut_fv_cnt;
        tx_q = '{8'h11, 8'h22, SYNC, 8'h03, SYNC, 8'h05, 8'h00, 8'h00, 8'h01, 8'h04};
        send_q();
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL resync_err: got %0d want 1", err_cnt); end
        total++; if (ext_data !== 32'h00000105) begin bad++; $display("FAIL resync_ext: got %h want 00000105", ext_data); end
        total++; if (dut_fv_cnt - fv0 !== 1) begin bad++; $display("FAIL resync_pulses: got %0d want 1", dut_fv_cnt - fv0); end
    endtask

    task automatic test_gap();
        do_reset();
        tx_q = '{SYNC, 8'h03, 8'h00};
        send_q();
        idle(GAP - 1);
        tx_q = '{8'h12, 8'h34, 8'h25};
        send_q();
        total++; if (ext_data !== 32'h00123403) begin bad++; $display("FAIL gap_below: got %h want 00123403", ext_data); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL gap_below_err: got %0d want 0", err_cnt); end
        tx_q = '{SYNC, 8'h07, 8'h00};
        send_q();
        idle(GAP - 1);
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL gap_early: got %0d want 0", err_cnt); end
        idle(1);
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL gap_expire: got %0d want 1", err_cnt); end
        tx_q = '{8'h12, 8'h34, 8'h21};
        send_q();
        total++; if (ext_data !== 32'h00123403) begin bad++; $display("FAIL gap_hunt: got %h want 00123403", ext_data); end
        send_frame(8'h09, 8'h00, 8'h00, 8'h42);
        total++; if (ext_data !== 32'h00004209) begin bad++; $display("FAIL gap_after: got %h want 00004209", ext_data); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL gap_after_err: got %0d want 1", err_cnt); end
    endtask

    task automatic test_link_timeout();
        int div0;
        do_reset();
        div0 = div_cnt;
        send_frame(8'h03, 8'h00, 8'h12, 8'h34);
        idle(LINK - 1);
        total++; if (link_up !== 1'b1) begin bad++; $display("FAIL link_before: got %b want 1", link_up); end
        total++; if (ext_data !== 32'h00123403) begin bad++; $display("FAIL link_before_ext: got %h want 00123403", ext_data); end
        idle(1);
        total++; if (link_up !== 1'b0) begin bad++; $display("FAIL link_down: got %b want 0", link_up); end
        total++; if (ext_data !== 32'h0) begin bad++; $display("FAIL link_down_ext: got %h want 0", ext_data); end
        idle(20);
        total++; if (link_up !== 1'b0) begin bad++; $display("FAIL link_held: got %b want 0", link_up); end
        send_frame(8'h07, 8'h98, 8'h76, 8'h54);
        total++; if (link_up !== 1'b1) begin bad++; $display("FAIL link_restore: got %b want 1", link_up); end
        total++; if (ext_data !== 32'h98765407) begin bad++; $display("FAIL link_restore_ext: got %h want 98765407", ext_data); end
        idle(LINK - 6);
        send_frame(8'h05, 8'h00, 8'h00, 8'h01);
        total++; if (link_up !== 1'b1) begin bad++; $display("FAIL link_tie: got %b want 1", link_up); end
        total++; if (ext_data !== 32'h00000105) begin bad++; $display("FAIL link_tie_ext: got %h want 00000105", ext_data); end
        total++; if (div_cnt !== div0) begin bad++; $display("FAIL link_model: got %0d divergent cycles want 0", div_cnt - div0); end
    endtask

    task automatic rand_gap();
        int n;
        n = ($urandom_range(0, 11) == 0) ? GAP + $urandom_range(0, 4) : $urandom_range(0, 2);
        idle(n);
    endtask

    task automatic test_random();
        int div0, dfv0, mfv0;
        logic [7:0] fb[5];
        int kind;
        do_reset();
        div0 = div_cnt;
        dfv0 = dut_fv_cnt;
        mfv0 = mdl_fv_cnt;
        for (int it = 0; it < 150; it++) begin
            repeat ($urandom_range(0, 2)) tick(1, 8'($urandom));
            fb[0] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            fb[1] = rand_bcd();
            fb[2] = rand_bcd();
            fb[3] = rand_bcd();
            kind  = $urandom_range(0, 7);
            if (kind == 1) fb[$urandom_range(1, 3)] = 8'($urandom);
            if (kind == 2) fb[$urandom_range(1, 3)] = SYNC;
            fb[4] = csum(fb[0], fb[1], fb[2], fb[3]);
            if (kind == 0) fb[4] = fb[4] ^ 8'(1 << $urandom_range(0, 7));
            tick(1, SYNC);
            for (int k = 0; k < 5; k++) begin
                if ($urandom_range(0, 3) == 0) rand_gap();
                tick(1, fb[k]);
            end
        end
        idle(3);
        total++; if (div_cnt !== div0) begin bad++; $display("FAIL rand_model: got %0d divergent cycles want 0", div_cnt - div0); end
        total++; if (dut_fv_cnt - dfv0 !== mdl_fv_cnt - mfv0) begin bad++; $display("FAIL rand_pulses: got %0d want %0d", dut_fv_cnt - dfv0, mdl_fv_cnt - mfv0); end
        total++; if (err_cnt !== 8'(m_err)) begin bad++; $display("FAIL rand_err: got %0d want %0d", err_cnt, m_err); end
    endtask

    task automatic test_saturation();
        int fv0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tx_q = '{SYNC, 8'h03, 8'h00, 8'h12, 8'h34, 8'h00};
            send_q();
            if (i == 253) begin
                total++; if (err_cnt !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d want 254", err_cnt); end
            end
        end
        total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_255: got %0d want 255", err_cnt); end
        send_frame(8'h03, 8'h00, 8'h12, 8'h34);
        tx_q = '{SYNC, 8'h07, 8'h98};
        send_q();
        @(negedge clk);
        rst      = 1'b1;
        rx_empty = 1'b0;
        rx_data  = 8'h76;
        @(posedge clk);
        #1;
        total++; if (ext_data !== 32'h0) begin bad++; $display("FAIL midrst_ext: got %h want 0", ext_data); end
        total++; if (link_up !== 1'b0) begin bad++; $display("FAIL midrst_link: got %b want 0", link_up); end
        total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL midrst_err: got %0d want 0", err_cnt); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL midrst_fv: got %b want 0", frame_valid); end
        total++; if (rd_uart !== 1'b0) begin bad++; $display("FAIL midrst_rd: got %b want 0", rd_uart); end
        model_reset();
        rst = 1'b0;
        fv0 = dut_fv_cnt;
        tx_q = '{8'h76, 8'h54, 8'hBD};
        send_q();
        idle(2);
        total++; if (dut_fv_cnt !== fv0) begin bad++; $display("FAIL midrst_partial: got %0d pulses want 0", dut_fv_cnt - fv0); end
        total++; if (ext_data !== 32'h0) begin bad++; $display("FAIL midrst_partial_ext: got %h want 0", ext_data); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_back_to_back();
        test_bad_frames();
        test_resync();
        test_gap();
        test_link_timeout();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
